mrc_desc_rcv: RTL and testbench

Receiver end of the WU-decoder-to-memory-read-controller descriptor interface (wud__mrc__*). It accepts multi-beat descriptors, where each beat carries OPT_PER_INST option type/value tuples delimited by cntl. It parses the recognised option types into a flat read descriptor and queues completed descriptors in a 2-entry FIFO for the memory read engine. It sits at the input of the MRC, one instance per manager.

---
 rtl/mrc_desc_rcv.sv | 229 ++++++++++++++++++++++
 tb/tb_mrc_desc_rcv.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrc_desc_rcv.sv
// mrc_desc_rcv: descriptor receiver at the MRC input.
// Parses option tuples into read descriptors, queues them two deep.
module mrc_desc_rcv #(
  parameter int OPT_PER_INST = 3,
  parameter int OPT_TYPE_W   = 8,
  parameter int OPT_VALUE_W  = 24,
  parameter int NUM_LANES_W  = 6
) (
  input  logic                                clk,
  input  logic                                reset_poweron,
  input  logic                                wud__mrc__valid,
  output logic                                mrc__wud__ready,
  input  logic [1:0]                          wud__mrc__cntl,
  input  logic [OPT_PER_INST*OPT_TYPE_W-1:0]  wud__mrc__option_type,
  input  logic [OPT_PER_INST*OPT_VALUE_W-1:0] wud__mrc__option_value,
  output logic                                desc_valid,
  input  logic                                desc_ready,
  output logic [NUM_LANES_W-1:0]              desc_num_lanes,
  output logic [OPT_VALUE_W-1:0]              desc_start_addr,
  output logic [OPT_VALUE_W-1:0]              desc_num_words,
  output logic                                desc_incomplete,
  output logic [7:0]                          desc_id,
  output logic                                err_framing,
  output logic                                err_unknown_opt
);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_e;

  typedef struct packed {
    logic [NUM_LANES_W-1:0] lanes;
    logic [OPT_VALUE_W-1:0] addr;
    logic [OPT_VALUE_W-1:0] words;
    logic                   has_addr;
    logic                   has_words;
  } acc_t;

  typedef struct packed {
    logic [NUM_LANES_W-1:0] lanes;
    logic [OPT_VALUE_W-1:0] addr;
    logic [OPT_VALUE_W-1:0] words;
    logic                   incomplete;
    logic [7:0]             id;
  } ent_t;

  state_e state_q, state_d;

  acc_t acc_q, acc_d;
  acc_t acc_new;
  ent_t ent_new;
  ent_t head_q, head_d;
  ent_t tail_q, tail_d;

  logic [1:0] cnt_q, cnt_d;
  logic [7:0] id_q, id_d;
  logic       rdy_q, rdy_d;
  logic       ferr_q, ferr_d;
  logic       unk_q, unk_d;

  logic                   fire;
  logic                   som;
  logic                   eom;
  logic                   apply;
  logic                   push;
  logic                   pop;
  logic                   ferr_hit;
  logic                   unk_hit;
  logic [OPT_TYPE_W-1:0]  cur_t;
  logic [OPT_VALUE_W-1:0] cur_v;

  assign fire = wud__mrc__valid && rdy_q;
  assign som  = wud__mrc__cntl[0];
  assign eom  = wud__mrc__cntl[1];
  assign pop  = (cnt_q != 2'd0) && desc_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a beat with EOM always closes the frame
  always_comb begin
    state_d = state_q;
    if (fire) begin
      unique case (state_q)
        S_IDLE: begin
          if (som && !eom) state_d = S_ACCUM;
        end
        S_ACCUM: begin
          if (eom) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: beat apply, push, framing error
  always_comb begin
    apply    = 1'b0;
    push     = 1'b0;
    ferr_hit = 1'b0;
    if (fire) begin
      unique case (state_q)
        S_IDLE: begin
          apply    = som;
          push     = som && eom;
          ferr_hit = !som;
        end
        S_ACCUM: begin
          apply    = 1'b1;
          push     = eom;
          ferr_hit = som;
        end
        default: begin
          apply    = 1'b0;
        end
      endcase
    end
  end

  // Tuple decode: SOM clears, then tuples apply in index order
  always_comb begin
    acc_new = som ? '0 : acc_q;
    unk_hit = 1'b0;
    cur_t   = '0;
    cur_v   = '0;
    for (int i = 0; i < OPT_PER_INST; i++) begin
      cur_t = wud__mrc__option_type[i*OPT_TYPE_W +: OPT_TYPE_W];
      cur_v = wud__mrc__option_value[i*OPT_VALUE_W +: OPT_VALUE_W];
      case (cur_t)
        OPT_TYPE_W'(0): begin
          acc_new = acc_new;
        end
        OPT_TYPE_W'(1): begin
          acc_new.lanes = cur_v[NUM_LANES_W-1:0];
        end
        OPT_TYPE_W'(2): begin
          acc_new.addr     = cur_v;
          acc_new.has_addr = 1'b1;
        end
        OPT_TYPE_W'(3): begin
          acc_new.words     = cur_v;
          acc_new.has_words = 1'b1;
        end
        default: begin
          unk_hit = 1'b1;
        end
      endcase
    end
  end

  // Completed descriptor built from this beat's result
  always_comb begin
    ent_new.lanes      = acc_new.lanes;
    ent_new.addr       = acc_new.addr;
    ent_new.words      = acc_new.words;
    ent_new.incomplete = !(acc_new.has_addr && acc_new.has_words);
    ent_new.id         = id_q;
  end

  // Accumulator, id counter and sticky error next state
  always_comb begin
    acc_d  = apply ? acc_new : acc_q;
    id_d   = push ? id_q + 8'd1 : id_q;
    ferr_d = ferr_q || ferr_hit;
    unk_d  = unk_q || (apply && unk_hit);
  end

  // Two-entry FIFO: head is the output register, tail backs it up
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop && cnt_q == 2'd2) head_d = tail_q;
    if (push) begin
      if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
        head_d = ent_new;
      end else begin
        tail_d = ent_new;
      end
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    rdy_d = cnt_d < 2'd2;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      acc_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      id_q   <= 8'd0;
      rdy_q  <= 1'b0;
      ferr_q <= 1'b0;
      unk_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      id_q   <= id_d;
      rdy_q  <= rdy_d;
      ferr_q <= ferr_d;
      unk_q  <= unk_d;
    end
  end

  assign mrc__wud__ready = rdy_q;
  assign desc_valid      = cnt_q != 2'd0;
  assign desc_num_lanes  = head_q.lanes;
  assign desc_start_addr = head_q.addr;
  assign desc_num_words  = head_q.words;
  assign desc_incomplete = head_q.incomplete;
  assign desc_id         = head_q.id;
  assign err_framing     = ferr_q;
  assign err_unknown_opt = unk_q;

endmodule

// File: tb/tb_mrc_desc_rcv.sv
// tb_mrc_desc_rcv: directed checks of the descriptor receiver.
// Each scenario task drives beats and compares head outputs inline.
module tb_mrc_desc_rcv;

  localparam logic [1:0] MOM  = 2'b00;
  localparam logic [1:0] SOM  = 2'b01;
  localparam logic [1:0] EOM  = 2'b10;
  localparam logic [1:0] SOME = 2'b11;

  logic        clk = 1'b0;
  logic        reset_poweron = 1'b1;
  logic        valid = 1'b0;
  logic        rdy;
  logic [1:0]  cntl = 2'b00;
  logic [23:0] otype = '0;
  logic [71:0] oval = '0;
  logic        desc_valid;
  logic        desc_ready = 1'b0;
  logic [5:0]  lanes;
  logic [23:0] addr;
  logic [23:0] words;
  logic        inc;
  logic [7:0]  id;
  logic        ferr;
  logic        uerr;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mrc_desc_rcv dut (
    .clk                    (clk),
    .reset_poweron          (reset_poweron),
    .wud__mrc__valid        (valid),
    .mrc__wud__ready        (rdy),
    .wud__mrc__cntl         (cntl),
    .wud__mrc__option_type  (otype),
    .wud__mrc__option_value (oval),
    .desc_valid             (desc_valid),
    .desc_ready             (desc_ready),
    .desc_num_lanes         (lanes),
    .desc_start_addr        (addr),
    .desc_num_words         (words),
    .desc_incomplete        (inc),
    .desc_id                (id),
    .err_framing            (ferr),
    .err_unknown_opt        (uerr)
  );

  function automatic logic [23:0] ty(input logic [7:0] a, b, c);
    return {c, b, a};
  endfunction

  function automatic logic [71:0] va(input logic [23:0] a, b, c);
    return {c, b, a};
  endfunction

  task automatic send_beat(input logic [1:0] c, input logic [23:0] t,
                           input logic [71:0] v);
    int n;
    @(negedge clk);
    valid = 1'b1;
    cntl  = c;
    otype = t;
    oval  = v;
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      $display("FAIL send_timeout ready stuck low cntl=%b", c);
      valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0;
    reset_poweron = 1'b1;
    repeat (2) @(negedge clk);
    reset_poweron = 1'b0;
  endtask

  task automatic test_reset();
    reset_poweron = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rdy !== 1'b0) $display("FAIL rst_ready got %b exp 0", rdy);
    else passed++;
    checks++;
    if (desc_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", desc_valid);
    else passed++;
    checks++;
    if ({lanes, addr, words, inc, id} !== 63'd0)
      $display("FAIL rst_fields got %h exp 0", {lanes, addr, words, inc, id});
    else passed++;
    checks++;
    if ({ferr, uerr} !== 2'b00) $display("FAIL rst_errs got %b exp 00", {ferr, uerr});
    else passed++;
    reset_poweron = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) $display("FAIL rst_ready_after got %b exp 1", rdy);
    else passed++;
  endtask

  task automatic test_single();
    desc_ready = 1'b1;
    send_beat(SOME, ty(1, 2, 3), va(24'd4, 24'h001000, 24'h40));
    @(negedge clk);
    checks++;
    if (desc_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", desc_valid);
    else passed++;
    checks++;
    if ({lanes, addr, words, inc, id} !== {6'd4, 24'h001000, 24'h40, 1'b0, 8'd0})
      $display("FAIL single_fields got %h/%h/%h/%b/%h exp 4/001000/40/0/0",
               lanes, addr, words, inc, id);
    else passed++;
    @(negedge clk);
    checks++;
    if (desc_valid !== 1'b0) $display("FAIL single_pop got %b exp 0", desc_valid);
    else passed++;
  endtask

  task automatic test_multi();
    desc_ready = 1'b0;
    send_beat(SOM, ty(2, 0, 1), va(24'h10, 24'h0, 24'd2));
    send_beat(MOM, ty(0, 0, 0), va(24'h5, 24'h6, 24'h7));
    send_beat(EOM, ty(2, 0, 0), va(24'h20, 24'h0, 24'h0));
    @(negedge clk);
    checks++;
    if ({desc_valid, lanes, addr, words, inc, id} !==
        {1'b1, 6'd2, 24'h20, 24'h0, 1'b1, 8'd1})
      $display("FAIL multi_fields got v%b %h/%h/%h/%b/%h exp v1 2/20/0/1/1",
               desc_valid, lanes, addr, words, inc, id);
    else passed++;
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
    checks++;
    if (desc_valid !== 1'b0) $display("FAIL multi_pop got %b exp 0", desc_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    desc_ready = 1'b0;
    send_beat(SOME, ty(1, 2, 3), va(24'd1, 24'h100, 24'h10));
    send_beat(SOME, ty(1, 2, 3), va(24'd2, 24'h200, 24'h20));
    @(negedge clk);
    checks++;
    if ({rdy, desc_valid, id} !== {1'b0, 1'b1, 8'd2})
      $display("FAIL b2b_full got rdy%b v%b id%h exp rdy0 v1 id02", rdy, desc_valid, id);
    else passed++;
    valid = 1'b1;
    cntl  = SOME;
    otype = ty(1, 2, 3);
    oval  = va(24'd3, 24'h300, 24'h30);
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy, id, lanes} !== {1'b0, 8'd2, 6'd1})
      $display("FAIL b2b_stall got rdy%b id%h l%h exp rdy0 id02 l01", rdy, id, lanes);
    else passed++;
    desc_ready = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b0) $display("FAIL b2b_pop_cycle_ready got %b exp 0", rdy);
    else passed++;
    @(negedge clk);
    checks++;
    if ({rdy, id, lanes} !== {1'b1, 8'd3, 6'd2})
      $display("FAIL b2b_second got rdy%b id%h l%h exp rdy1 id03 l02", rdy, id, lanes);
    else passed++;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({desc_valid, id, lanes, addr} !== {1'b1, 8'd4, 6'd3, 24'h300})
      $display("FAIL b2b_third got v%b id%h l%h a%h exp v1 id04 l03 a300",
               desc_valid, id, lanes, addr);
    else passed++;
    @(negedge clk);
    desc_ready = 1'b0;
    checks++;
    if (desc_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", desc_valid);
    else passed++;
  endtask

  task automatic test_framing();
    do_reset();
    desc_ready = 1'b0;
    send_beat(MOM, ty(1, 2, 3), va(24'd9, 24'h9, 24'h9));
    @(negedge clk);
    checks++;
    if ({ferr, desc_valid} !== 2'b10)
      $display("FAIL frm_drop got ferr%b v%b exp ferr1 v0", ferr, desc_valid);
    else passed++;
    send_beat(SOM, ty(1, 2, 3), va(24'd7, 24'h55, 24'h66));
    send_beat(SOME, ty(3, 0, 0), va(24'h9, 24'h0, 24'h0));
    @(negedge clk);
    checks++;
    if ({desc_valid, lanes, addr, words, inc, id} !==
        {1'b1, 6'd0, 24'h0, 24'h9, 1'b1, 8'd0})
      $display("FAIL frm_desc got v%b %h/%h/%h/%b/%h exp v1 0/0/9/1/0",
               desc_valid, lanes, addr, words, inc, id);
    else passed++;
    checks++;
    if ({ferr, uerr} !== 2'b10) $display("FAIL frm_errs got %b exp 10", {ferr, uerr});
    else passed++;
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
    checks++;
    if (desc_valid !== 1'b0) $display("FAIL frm_single got %b exp 0", desc_valid);
    else passed++;
  endtask

  task automatic test_unknown();
    do_reset();
    desc_ready = 1'b0;
    send_beat(SOME, ty(1, 8'h7F, 2), va(24'd5, 24'hFFFFFF, 24'h300));
    @(negedge clk);
    checks++;
    if ({ferr, uerr} !== 2'b01) $display("FAIL unk_errs got %b exp 01", {ferr, uerr});
    else passed++;
    checks++;
    if ({lanes, addr, words, inc, id} !== {6'd5, 24'h300, 24'h0, 1'b1, 8'd0})
      $display("FAIL unk_fields got %h/%h/%h/%b/%h exp 5/300/0/1/0",
               lanes, addr, words, inc, id);
    else passed++;
  endtask

  task automatic test_id_wrap();
    logic [7:0] e;
    desc_ready = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      e = 8'(k);
      send_beat(SOME, ty(1, 0, 0), va(24'(k), 24'h0, 24'h0));
      @(negedge clk);
      checks++;
      if (id !== e) $display("FAIL wrap_id k=%0d got %h exp %h", k, id, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    desc_ready = 1'b0;
    send_beat(SOME, ty(1, 2, 3), va(24'd1, 24'h1, 24'h1));
    send_beat(SOM, ty(1, 2, 3), va(24'd3, 24'h3, 24'h3));
    @(negedge clk);
    checks++;
    if (desc_valid !== 1'b1) $display("FAIL mid_pre_valid got %b exp 1", desc_valid);
    else passed++;
    reset_poweron = 1'b1;
    @(negedge clk);
    checks++;
    if ({desc_valid, ferr, uerr} !== 3'b000)
      $display("FAIL mid_rst got v%b ferr%b uerr%b exp 000", desc_valid, ferr, uerr);
    else passed++;
    reset_poweron = 1'b0;
    send_beat(SOM, ty(2, 3, 1), va(24'hA, 24'hB, 24'd2));
    send_beat(EOM, ty(0, 0, 0), va(24'h0, 24'h0, 24'h0));
    @(negedge clk);
    checks++;
    if ({desc_valid, lanes, addr, words, inc, id} !==
        {1'b1, 6'd2, 24'hA, 24'hB, 1'b0, 8'd0})
      $display("FAIL mid_fresh got v%b %h/%h/%h/%b/%h exp v1 2/a/b/0/0",
               desc_valid, lanes, addr, words, inc, id);
    else passed++;
    checks++;
    if (ferr !== 1'b0) $display("FAIL mid_ferr got %b exp 0", ferr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_framing();
    test_unknown();
    test_id_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
